// File: rtl/rv_exec_datapath.sv
// RV32I execute-stage datapath: 32x32 register file with two combinational read
// ports, funct3/funct7/format ALU decode, and a registered single-cycle ALU result.
module rv_exec_datapath #(
    parameter int DEBUG = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [3:0]  fmt,
    input  logic [31:0] alu_a,
    input  logic [31:0] alu_b,
    output logic [3:0]  alu_ctr,
    output logic [31:0] alu_result
);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;

    localparam logic [3:0] FMT_R = 4'd0;
    localparam logic [3:0] FMT_I = 4'd1;

    logic [31:0] regs [32];
    alu_op_t     alu_op;
    logic [4:0]  shamt;
    logic [31:0] alu_next;
    logic        unused_bits;

    // Only funct7[5] distinguishes SUB/SRA; DEBUG tracing has no hardware counterpart.
    assign unused_bits = ^{funct7[6], funct7[4:0], (DEBUG != 0)};

    // x0 is hardwired to zero on read; reads never see a same-cycle write.
    assign rdata1 = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rdata2 = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (we && (rd != 5'd0)) begin
            regs[rd] <= wdata;
        end
    end

    // Only R and I formats select a real operation; everything else computes an address sum.
    always_comb begin
        alu_op = ALU_ADD;
        if ((fmt == FMT_R) || (fmt == FMT_I)) begin
            case (funct3)
                3'd0: alu_op = ((fmt == FMT_R) && funct7[5]) ? ALU_SUB : ALU_ADD;
                3'd1: alu_op = ALU_SLL;
                3'd2: alu_op = ALU_SLT;
                3'd3: alu_op = ALU_SLTU;
                3'd4: alu_op = ALU_XOR;
                3'd5: alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
                3'd6: alu_op = ALU_OR;
                default: alu_op = ALU_AND;
            endcase
        end
    end

    assign alu_ctr = alu_op;
    assign shamt   = alu_b[4:0];

    always_comb begin
        alu_next = 32'd0;
        case (alu_op)
            ALU_ADD:  alu_next = alu_a + alu_b;
            ALU_SUB:  alu_next = alu_a - alu_b;
            ALU_SLL:  alu_next = alu_a << shamt;
            ALU_SLT:  alu_next = {31'd0, ($signed(alu_a) < $signed(alu_b))};
            ALU_SLTU: alu_next = {31'd0, (alu_a < alu_b)};
            ALU_XOR:  alu_next = alu_a ^ alu_b;
            ALU_SRL:  alu_next = alu_a >> shamt;
            ALU_SRA:  alu_next = 32'($signed(alu_a) >>> shamt);
            ALU_OR:   alu_next = alu_a | alu_b;
            ALU_AND:  alu_next = alu_a & alu_b;
            default:  alu_next = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_result <= 32'd0;
        end else begin
            alu_result <= alu_next;
        end
    end

endmodule

// File: tb/tb_rv_exec_datapath.sv
// Scoreboard bench for rv_exec_datapath: directed vectors plus randomized traffic
// compared against an arithmetic reference model of the register file and ALU.
module tb_rv_exec_datapath;

    logic        clk;
    logic        reset;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [3:0]  fmt;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctr;
    logic [31:0] alu_result;

    int          assert_count = 0;
    int          fail_count   = 0;
    logic [31:0] ref_regs [32];
    bit          regs_known = 0;
    logic [31:0] expq [$];

    rv_exec_datapath #(.DEBUG(0)) dut (
        .clk        (clk),
        .reset      (reset),
        .rs1        (rs1),
        .rs2        (rs2),
        .rd         (rd),
        .wdata      (wdata),
        .we         (we),
        .rdata1     (rdata1),
        .rdata2     (rdata2),
        .funct3     (funct3),
        .funct7     (funct7),
        .fmt        (fmt),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctr    (alu_ctr),
        .alu_result (alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [3:0] modelCtr(input logic [3:0] f, input logic [2:0] f3, input logic [6:0] f7);
        if (f > 4'd1) return 4'd0;
        case (f3)
            3'd0: return (f == 4'd0 && f7[5]) ? 4'd1 : 4'd0;
            3'd1: return 4'd2;
            3'd2: return 4'd3;
            3'd3: return 4'd4;
            3'd4: return 4'd5;
            3'd5: return f7[5] ? 4'd7 : 4'd6;
            3'd6: return 4'd8;
            default: return 4'd9;
        endcase
    endfunction

    // Shifts are modelled as multiply/divide by powers of two, SRA as floor division.
    function automatic logic [31:0] modelAlu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        longint unsigned ua  = a;
        longint unsigned ub  = b;
        longint          sa  = longint'($signed(a));
        longint          sb  = longint'($signed(b));
        int              sh  = int'(b[4:0]);
        longint          div = longint'(64'd1 << sh);
        case (c)
            4'd0: return 32'(ua + ub);
            4'd1: return 32'(ua + 64'h1_0000_0000 - ub);
            4'd2: return 32'(ua * 64'(div));
            4'd3: return (sa < sb) ? 32'd1 : 32'd0;
            4'd4: return (ua < ub) ? 32'd1 : 32'd0;
            4'd5: return a ^ b;
            4'd6: return 32'(ua / 64'(div));
            4'd7: return (sa >= 0) ? 32'(sa / div) : 32'((sa - (div - 1)) / div);
            4'd8: return a | b;
            4'd9: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] modelRead(input logic [4:0] addr);
        return (addr == 5'd0) ? 32'd0 : ref_regs[addr];
    endfunction

    task automatic applyStimulus(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                                 input logic [4:0] d, input logic [31:0] wd, input logic w,
                                 input logic [3:0] f, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [31:0] a, input logic [31:0] b);
        logic [3:0] exp_ctr;
        @(negedge clk);
        reset = r; rs1 = a1; rs2 = a2; rd = d; wdata = wd; we = w;
        fmt = f; funct3 = f3; funct7 = f7; alu_a = a; alu_b = b;
        #1;
        exp_ctr = modelCtr(f, f3, f7);
        checkOutput("alu_ctr", {28'd0, alu_ctr}, {28'd0, exp_ctr});
        if (regs_known) begin
            checkOutput("rdata1", rdata1, modelRead(a1));
            checkOutput("rdata2", rdata2, modelRead(a2));
        end
        if (r) begin
            expq.push_back(32'd0);
            for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
            regs_known = 1;
        end else begin
            expq.push_back(modelAlu(exp_ctr, a, b));
            if (w && d != 5'd0) ref_regs[d] = wd;
        end
    endtask

    initial begin : monitor
        logic [31:0] exp_val;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                exp_val = expq.pop_front();
                checkOutput("alu_result", alu_result, exp_val);
            end
        end
    end

    initial begin : stimulus
        logic [3:0] rf;
        reset = 1'b0; rs1 = '0; rs2 = '0; rd = '0; wdata = '0; we = 1'b0;
        fmt = '0; funct3 = '0; funct7 = '0; alu_a = '0; alu_b = '0;

        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);

        // Register file write/read, x0 discard, and no-bypass behaviour
        applyStimulus(0, 0, 0, 5, 32'h12345678, 1, 2, 0, 0, 1, 2);
        applyStimulus(0, 5, 0, 0, 32'hFFFFFFFF, 1, 2, 0, 0, 3, 4);
        checkOutput("x5_read", rdata1, 32'h12345678);
        applyStimulus(0, 5, 0, 0, 0, 0, 2, 0, 0, 0, 0);
        checkOutput("x0_read", rdata2, 32'd0);
        applyStimulus(0, 0, 0, 3, 32'h1, 1, 2, 0, 0, 0, 0);
        applyStimulus(0, 3, 0, 3, 32'hA, 1, 2, 0, 0, 0, 0);
        checkOutput("x3_before_edge", rdata1, 32'h1);
        applyStimulus(0, 3, 0, 0, 0, 0, 2, 0, 0, 0, 0);
        checkOutput("x3_after_edge", rdata1, 32'hA);

        // ALU directed vectors
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 7'h20, 32'd5, 32'd7);
        checkOutput("sub_ctr", {28'd0, alu_ctr}, 32'd1);
        @(posedge clk); #2;
        checkOutput("sub_result", alu_result, 32'hFFFFFFFE);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5, 7'h20, 32'h80000000, 32'd4);
        checkOutput("srai_ctr", {28'd0, alu_ctr}, 32'd7);
        @(posedge clk); #2;
        checkOutput("srai_result", alu_result, 32'hF8000000);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5, 7'h00, 32'h80000000, 32'd4);
        checkOutput("srli_ctr", {28'd0, alu_ctr}, 32'd6);
        @(posedge clk); #2;
        checkOutput("srli_result", alu_result, 32'h08000000);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 2, 0, 32'hFFFFFFFF, 32'd1);
        @(posedge clk); #2;
        checkOutput("slt_result", alu_result, 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 3, 0, 32'hFFFFFFFF, 32'd1);
        @(posedge clk); #2;
        checkOutput("sltu_result", alu_result, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 5, 7, 7'h20, 32'd100, 32'd23);
        checkOutput("branch_ctr", {28'd0, alu_ctr}, 32'd0);
        @(posedge clk); #2;
        checkOutput("branch_result", alu_result, 32'd123);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 7'h20, 32'd9, 32'd4);
        checkOutput("addi_ctr", {28'd0, alu_ctr}, 32'd0);

        // Reset wins over a simultaneous write, then sweep every register
        applyStimulus(0, 0, 0, 7, 32'h55, 1, 0, 0, 0, 32'd1, 32'd1);
        applyStimulus(1, 7, 0, 7, 32'h77, 1, 0, 0, 0, 32'd3, 32'd4);
        checkOutput("x7_loaded", rdata1, 32'h55);
        @(posedge clk); #2;
        checkOutput("reset_alu_result", alu_result, 32'd0);
        checkOutput("x7_after_reset", rdata1, 32'd0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 5'(2 * i), 5'(2 * i + 1), 0, 0, 0, 0, 0, 0, 32'(i), 32'(i));
        end

        // Randomized traffic, biased towards R/I formats with occasional reset
        for (int n = 0; n < 400; n++) begin
            rf = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1));
            applyStimulus(($urandom_range(0, 49) == 0),
                          5'($urandom), 5'($urandom), 5'($urandom), $urandom, 1'($urandom),
                          rf, 3'($urandom), ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                          $urandom,
                          ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40)));
        end

        for (int k = 0; k < 10 && expq.size() > 0; k++) @(posedge clk);
        #2;
        if (expq.size() > 0) begin
            assert_count++;
            fail_count++;
            $display("[TB] FAIL drain: got %0d pending results expected 0", expq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
